// File: rtl/dct_pkg.sv
// Shared parameters and FSM state encoding for the serial 8x8 IDCT.
package dct_pkg;

  localparam int N         = 8;
  localparam int COEF_W    = 32;
  localparam int BASIS_W   = 9;
  localparam int Q_FRAC    = 8;
  localparam int ACC_W     = 56;

  // Derived widths: c*c is Q16 in 18 bits, coef*(c*c) is 50 bits.
  localparam int BPROD_W   = 2 * BASIS_W;
  localparam int CPROD_W   = COEF_W + BPROD_W;
  localparam int OUT_SHIFT = 2 * Q_FRAC;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_MAC  = 2'd1,
    ST_EMIT = 2'd2
  } state_t;

endpackage

// File: rtl/idct_basis_lut.sv
// 1D IDCT basis c(k,n) = round(256*a(k)*cos((2n+1)k*pi/16)), signed Q8.
// The 8x8 table is folded onto the nine distinct cosine magnitudes by
// reducing the angle (2n+1)*k modulo 32 (units of pi/16).
module idct_basis_lut
  import dct_pkg::*;
(
  input  logic [2:0]                k,
  input  logic [2:0]                n,
  output logic signed [BASIS_W-1:0] c
);

  logic [4:0] ang;
  logic [4:0] fold;

  function automatic logic signed [BASIS_W-1:0] cos_q8(input logic [3:0] m);
    case (m)
      4'd0:    cos_q8 = 9'sd128;
      4'd1:    cos_q8 = 9'sd126;
      4'd2:    cos_q8 = 9'sd118;
      4'd3:    cos_q8 = 9'sd106;
      4'd4:    cos_q8 = 9'sd91;
      4'd5:    cos_q8 = 9'sd71;
      4'd6:    cos_q8 = 9'sd49;
      4'd7:    cos_q8 = 9'sd25;
      default: cos_q8 = 9'sd0;
    endcase
  endfunction

  // Angle reduction: cos is even about 0 and 16, odd about 8.
  always_comb begin
    ang  = {1'b0, n, 1'b1} * {2'b00, k};
    fold = (ang > 5'd16) ? (5'd0 - ang) : ang;
    if (k == 3'd0)
      c = 9'sd91;
    else if (fold > 5'd8)
      c = -cos_q8(4'(5'd16 - fold));
    else
      c = cos_q8(fold[3:0]);
  end

endmodule

// File: rtl/idct_8x8_serial.sv
// Serial 8x8 inverse DCT: loads 64 coefficients, then computes each output
// pixel with 64 sequential MACs over the separable basis, one pixel at a time.
//
// state   | meaning
// LOAD    | accept 64 coefficients into the buffer (in_ready=1)
// MAC     | accumulate 64 terms for pixel p
// EMIT    | hold pixel p on the output until out_ready
module idct_8x8_serial
  import dct_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [COEF_W-1:0] in_coef,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [COEF_W-1:0] out_pixel,
  output logic                     out_last
);

  localparam logic signed [ACC_W-1:0] PIX_MAX = 56'sh0000007fffffff;
  localparam logic signed [ACC_W-1:0] PIX_MIN = 56'shffffff80000000;
  localparam logic signed [ACC_W-1:0] RND     = 56'sd32768;

  state_t                     state;
  logic [5:0]                 idx;
  logic [5:0]                 p;
  logic [5:0]                 k;
  logic signed [ACC_W-1:0]    acc;
  logic signed [COEF_W-1:0]   coef_buf [64];

  logic signed [BASIS_W-1:0]  c_row;
  logic signed [BASIS_W-1:0]  c_col;
  logic signed [BPROD_W-1:0]  basis_prod;
  logic signed [CPROD_W-1:0]  coef_prod;
  logic signed [ACC_W-1:0]    acc_next;
  logic signed [ACC_W-1:0]    rounded;
  logic signed [COEF_W-1:0]   sat_pix;

  idct_basis_lut u_lut_row (.k(k[5:3]), .n(p[5:3]), .c(c_row));
  idct_basis_lut u_lut_col (.k(k[2:0]), .n(p[2:0]), .c(c_col));

  assign in_ready  = (state == ST_LOAD);
  assign out_valid = (state == ST_EMIT);
  assign out_last  = out_valid && (p == 6'd63);

  // Datapath: one MAC term, plus rounding and saturation of the final sum.
  always_comb begin
    basis_prod = c_row * c_col;
    coef_prod  = coef_buf[k] * basis_prod;
    acc_next   = acc + {{(ACC_W-CPROD_W){coef_prod[CPROD_W-1]}}, coef_prod};
    rounded    = (acc_next + RND) >>> OUT_SHIFT;
    if (rounded > PIX_MAX)
      sat_pix = 32'sh7fffffff;
    else if (rounded < PIX_MIN)
      sat_pix = 32'sh80000000;
    else
      sat_pix = rounded[COEF_W-1:0];
  end

  // Coefficient buffer, written only on a LOAD handshake; never reset.
  always_ff @(posedge clk) begin
    if (!rst && in_valid && in_ready)
      coef_buf[idx] <= in_coef;
  end

  // Control FSM, counters, accumulator and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_LOAD;
      idx       <= '0;
      p         <= '0;
      k         <= '0;
      acc       <= '0;
      out_pixel <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (in_valid) begin
            idx <= idx + 6'd1;
            if (idx == 6'd63) begin
              state <= ST_MAC;
              acc   <= '0;
              k     <= '0;
            end
          end
        end
        ST_MAC: begin
          acc <= acc_next;
          k   <= k + 6'd1;
          if (k == 6'd63) begin
            out_pixel <= sat_pix;
            state     <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            if (p == 6'd63) begin
              p     <= '0;
              state <= ST_LOAD;
            end else begin
              p     <= p + 6'd1;
              acc   <= '0;
              k     <= '0;
              state <= ST_MAC;
            end
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_idct_8x8_serial.sv
// Directed bench for idct_8x8_serial: single-coefficient blocks with
// hand-computed pixel rows/columns, plus stall, reset, hold and saturation cases.
module tb_idct_8x8_serial;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] in_coef;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] out_pixel;
  logic               out_last;

  idct_8x8_serial dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_coef(in_coef),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pixel(out_pixel), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    string              name;
    int                 pos;
    logic signed [31:0] coef;
    bit                 by_col;
    logic signed [31:0] exp [8];
  } vec_t;

  vec_t vecs [5];

  int checks   = 0;
  int failures = 0;

  logic signed [31:0] blk     [64];
  logic signed [31:0] got_pix [64];
  bit                 got_last[64];
  int  first_valid_cyc, last_hs_cyc, stall_bad, stalls, in_hs_during;
  bit  rand_ready = 1'b0;
  bit  hold_in    = 1'b0;
  logic signed [31:0] hold_coef = 32'sd12345;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s timeout waiting on DUT", name);
  endtask

  task automatic fill(input logic signed [31:0] v);
    for (int i = 0; i < 64; i++) blk[i] = v;
  endtask

  // Present blk[0..n-1]; in_valid is left high after the last word.
  task automatic send_block(input int n);
    int cyc;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_coef  = blk[i];
      cyc = 0;
      while (!in_ready && cyc < 300) begin
        @(negedge clk);
        cyc++;
      end
      if (!in_ready) begin
        timeout_fail("send_block");
        in_valid = 1'b0;
        return;
      end
    end
  endtask

  // Drain 64 pixels, recording values, last flags, stalls and timing.
  task automatic collect(input string name);
    int cyc;
    bit got;
    bit stall_set;
    logic signed [31:0] stall_pix;
    cyc = 0; first_valid_cyc = -1; last_hs_cyc = -1;
    stall_bad = 0; stalls = 0; in_hs_during = 0;
    stall_set = 1'b0; stall_pix = '0;
    for (int j = 0; j < 64; j++) begin
      got = 1'b0;
      while (!got && cyc < 64*300) begin
        @(negedge clk);
        cyc++;
        in_valid  = hold_in;
        if (hold_in) in_coef = hold_coef;
        if (in_valid && in_ready) in_hs_during++;
        out_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
        if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (out_valid) begin
          if (stall_set && out_pixel != stall_pix) stall_bad++;
          if (!out_ready) begin
            stalls++;
            stall_pix = out_pixel;
            stall_set = 1'b1;
          end else begin
            got_pix[j]  = out_pixel;
            got_last[j] = out_last;
            stall_set   = 1'b0;
            got         = 1'b1;
            last_hs_cyc = cyc;
          end
        end
      end
      if (!got) begin
        timeout_fail(name);
        in_valid = 1'b0;
        return;
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check({name, "_in_ready_after"}, in_ready, 1);
    check({name, "_no_extra_valid"}, out_valid, 0);
  endtask

  task automatic check_last(input string name);
    int bad;
    bad = 0;
    for (int j = 0; j < 64; j++)
      if (got_last[j] != (j == 63)) bad++;
    check({name, "_last_errors"}, bad, 0);
  endtask

  task automatic check_const(input string name, input logic signed [31:0] v);
    for (int j = 0; j < 64; j++)
      check($sformatf("%s_pix%0d", name, j), got_pix[j], v);
  endtask

  initial begin
    vecs[0].name = "dc256";   vecs[0].pos = 0;  vecs[0].coef = 256;  vecs[0].by_col = 0;
    vecs[0].exp  = '{32, 32, 32, 32, 32, 32, 32, 32};
    vecs[1].name = "zero";    vecs[1].pos = 0;  vecs[1].coef = 0;    vecs[1].by_col = 0;
    vecs[1].exp  = '{0, 0, 0, 0, 0, 0, 0, 0};
    vecs[2].name = "imp60";   vecs[2].pos = 48; vecs[2].coef = 1000; vecs[2].by_col = 0;
    vecs[2].exp  = '{68, -164, 164, -68, -68, 164, -164, 68};
    vecs[3].name = "imp01";   vecs[3].pos = 1;  vecs[3].coef = 1000; vecs[3].by_col = 1;
    vecs[3].exp  = '{175, 147, 99, 35, -35, -99, -147, -175};
    vecs[4].name = "dcneg";   vecs[4].pos = 0;  vecs[4].coef = -256; vecs[4].by_col = 0;
    vecs[4].exp  = '{-32, -32, -32, -32, -32, -32, -32, -32};

    rst = 1'b1; in_valid = 1'b0; in_coef = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_pixel", out_pixel, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);

    for (int t = 0; t < 5; t++) begin
      fill(0);
      blk[vecs[t].pos] = vecs[t].coef;
      send_block(64);
      collect(vecs[t].name);
      for (int j = 0; j < 64; j++)
        check($sformatf("%s_pix%0d", vecs[t].name, j), got_pix[j],
              vecs[t].exp[vecs[t].by_col ? (j % 8) : (j / 8)]);
      check_last(vecs[t].name);
      if (t == 0) begin
        check("latency_first_pixel", first_valid_cyc, 65);
        check("block_cycles", last_hs_cyc, 64*65);
      end
    end

    // Random backpressure on a DC block.
    fill(0); blk[0] = 256;
    send_block(64);
    rand_ready = 1'b1;
    collect("rand");
    rand_ready = 1'b0;
    check_const("rand", 32);
    check_last("rand");
    check("rand_stall_changes", stall_bad, 0);
    check("rand_saw_stalls", (stalls > 0) ? 1 : 0, 1);

    // Reset after 30 coefficients, then a full DC block.
    fill(777);
    send_block(30);
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    fill(0); blk[0] = 256;
    send_block(64);
    collect("rst_load");
    check_const("rst_load", 32);
    check_last("rst_load");

    // Reset in the middle of MAC for pixel 1, then a fresh block.
    fill(0); blk[0] = 256;
    send_block(64);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (100) @(negedge clk);
    check("mid_rst_pre_state", in_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_out_valid", out_valid, 0);
    @(negedge clk);
    check("mid_rst_in_ready", in_ready, 1);
    fill(0); blk[0] = -256;
    send_block(64);
    collect("mid_rst");
    check_const("mid_rst", -32);

    // in_valid held with other data during MAC/EMIT of block A.
    fill(0); blk[0] = 256;
    send_block(64);
    hold_in = 1'b1;
    collect("hold_a");
    hold_in = 1'b0;
    check("hold_in_handshakes", in_hs_during, 0);
    check_const("hold_a", 32);
    check_last("hold_a");
    fill(0); blk[0] = 1000;
    send_block(64);
    collect("hold_b");
    check("hold_b_pix0", got_pix[0], 1000*91*91 / 65536 + ((1000*91*91 % 65536) >= 32768 ? 1 : 0));

    // Saturation at both rails (pixel 0 sums 677^2 times the coefficient).
    fill(32'sh7fffffff);
    send_block(64);
    collect("sat_pos");
    check("sat_pos_pix0", got_pix[0], 64'sd2147483647);
    fill(32'sh80000000);
    send_block(64);
    collect("sat_neg");
    check("sat_neg_pix0", got_pix[0], -64'sd2147483648);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/idct_8x8_serial.md
IDCT_8X8_SERIAL -- requirements
Module: idct_8x8_serial

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port in_valid, input, 1, coefficient word valid.
REQ-004 SHALL have port in_ready, output, 1, block accepts coefficient this cycle.
REQ-005 SHALL have port in_coef, input, 32, signed DCT coefficient X[k1][k2], raster order: k1 major, k2 minor, 64 words per block.
REQ-006 SHALL have port out_valid, output, 1, pixel word valid.
REQ-007 SHALL have port out_ready, input, 1, downstream accepts pixel.
REQ-008 SHALL have port out_pixel, output, 32, signed reconstructed sample x[n1][n2], raster order: n1 major, n2 minor.
REQ-009 SHALL have port out_last, output, 1, high with out_valid on pixel 63 only.

Function
REQ-010 SHALL implement a 3-state FSM: LOAD, MAC, EMIT.
REQ-011 LOAD: in_ready=1; each in_valid&in_ready cycle writes in_coef to buffer[idx] and increments 6-bit idx; the transfer at idx=63 wraps idx to 0 and enters MAC next cycle.
REQ-012 MAC: in_ready=0, out_valid=0; one MAC per cycle over k=0..63 for current pixel p: acc += buffer[k] * c(k1,n1) * c(k2,n2); exactly 64 cycles, then EMIT.
REQ-013 Basis c(k,n) SHALL be round(256*a(k)*cos((2n+1)k*pi/16)), a(0)=sqrt(1/8), a(k>0)=0.5; signed 9-bit Q8 (c(0,n)=91, c(6,0)=49, c(6,1)=-118).
REQ-014 Arithmetic: basis product 18-bit signed Q16; coefficient product 50-bit signed; acc 56-bit signed, cleared at MAC entry, no wrap for any 32-bit input.
REQ-015 Output value SHALL be (acc + 32768) >>> 16 (arithmetic), saturated to [-2^31, 2^31-1].
REQ-016 EMIT: out_valid=1, out_pixel/out_last stable until out_valid&out_ready; on handshake, p<63 -> p+1, MAC; p=63 -> p=0, LOAD.
REQ-017 out_valid held with out_ready=0 SHALL stall indefinitely without changing out_pixel.
REQ-018 Per-pixel latency: 64 MAC cycles + 1 cycle to EMIT; block throughput >= 64*65 cycles with out_ready tied high.
REQ-019 in_valid during MAC/EMIT SHALL be ignored (in_ready=0); no coefficient lost or overwritten mid-block.
REQ-020 in_valid without data change across stalls is not required; input is sampled only on handshake.

Reset
REQ-021 On rst: state=LOAD, idx=0, p=0, acc=0, in_ready=1 next cycle after rst deasserts, out_valid=0, out_last=0, out_pixel=0.
REQ-022 rst asserted mid-LOAD, MAC or EMIT SHALL discard the partial block; buffer contents need not be cleared.
REQ-023 rst has priority over any simultaneous handshake.

Structure
REQ-024 Shared package dct_pkg SHALL hold N=8, COEF_W=32, BASIS_W=9, Q_FRAC=8, ACC_W=56, and the FSM state enum.
REQ-025 Sub-module idct_basis_lut SHALL hold the 8x8 1D basis table c(k,n), combinational, two instances (k1/n1, k2/n2) or one time-shared; no 2D 4096-entry table.
REQ-026 Coefficient buffer SHALL be a 64x32 register array or inferred single-port RAM, written only in LOAD.

Verification
REQ-027 DC block: X[0][0]=256, others 0, out_ready=1 -> all 64 pixels = 32, out_last on 64th only.
REQ-028 All-zero block -> 64 pixels = 0; in_ready returns high the cycle after pixel 63 handshake.
REQ-029 Impulse X[6][0]=1000 -> x[0][n2]=68, x[1][n2]=-164 for all n2; rows 6 and 7 mirror rows 1 and 0 in sign per cosine symmetry.
REQ-030 Random out_ready (50%) with DC block -> out_pixel constant 32 during stalls, exactly 64 handshakes, no extra out_valid.
REQ-031 rst pulsed after 30 coefficients loaded, then full DC block sent -> output matches REQ-027 exactly.
REQ-032 in_valid held high throughout MAC/EMIT of block A with block B data -> block A output unaffected; block B accepted only after LOAD re-entered.
